mouse_cursor_painter: RTL and testbench

//  Consumes decoded PS/2 mouse packets (9-bit signed X/Y deltas, button byte, one-cycle valid).

---
 rtl/mouse_cursor_painter.sv | 132 +++++++++++++
 tb/tb_mouse_cursor_painter.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mouse_cursor_painter.sv
// Mouse cursor integrator and brush painter: turns decoded PS/2 packets into a clamped
// cursor position and sweeps a square brush into the sand grid over a req/ack write port.
module mouse_cursor_painter #(
    parameter int H_RES   = 640,
    parameter int V_RES   = 480,
    parameter int BRUSH_R = 1
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [8:0] x_velocity_i,
    input  logic [8:0] y_velocity_i,
    input  logic [7:0] btn_i,
    input  logic       packet_valid_i,
    output logic [9:0] cursor_x_o,
    output logic [8:0] cursor_y_o,
    output logic       wr_req_o,
    output logic [9:0] wr_x_o,
    output logic [8:0] wr_y_o,
    output logic [1:0] wr_data_o,
    input  logic       wr_ack_i,
    output logic       busy_o
);

    // state  | meaning
    // IDLE   | waiting for a packet with a button held
    // SWEEP  | walking the brush offsets, issuing on-screen pixel writes
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SWEEP = 1'b1;

    localparam logic signed [10:0] X_MAX = 11'(H_RES - 1);
    localparam logic signed [10:0] Y_MAX = 11'(V_RES - 1);
    localparam logic signed [10:0] R_POS = 11'(BRUSH_R);
    localparam logic signed [10:0] R_NEG = 11'(-BRUSH_R);

    logic [0:0]         state;
    logic [9:0]         cx;
    logic [8:0]         cy;
    logic signed [10:0] ox;
    logic signed [10:0] oy;
    logic [1:0]         mat;

    logic               accept;
    logic               paint_start;
    logic signed [10:0] dx_ext;
    logic signed [10:0] dy_ext;
    logic signed [10:0] nx;
    logic signed [10:0] ny;
    logic [9:0]         nx_clamp;
    logic [8:0]         ny_clamp;
    logic signed [10:0] tx;
    logic signed [10:0] ty;
    logic               on_screen;
    logic               step;
    logic               unused_btn;

    assign unused_btn = ^{btn_i[5:4], btn_i[2]};

    assign accept      = packet_valid_i && btn_i[3];
    assign paint_start = accept && (btn_i[0] || btn_i[1]) && (state == ST_IDLE);

    assign dx_ext = btn_i[6] ? '0 : {{2{x_velocity_i[8]}}, x_velocity_i};
    assign dy_ext = btn_i[7] ? '0 : {{2{y_velocity_i[8]}}, y_velocity_i};

    // PS/2 +Y points up while screen row 0 is at the top, hence the subtraction
    assign nx = $signed({1'b0, cursor_x_o}) + dx_ext;
    assign ny = $signed({2'b00, cursor_y_o}) - dy_ext;

    always_comb begin
        nx_clamp = nx[9:0];
        if (nx[10])
            nx_clamp = '0;
        else if (nx > X_MAX)
            nx_clamp = X_MAX[9:0];

        ny_clamp = ny[8:0];
        if (ny[10])
            ny_clamp = '0;
        else if (ny > Y_MAX)
            ny_clamp = Y_MAX[8:0];
    end

    assign tx = $signed({1'b0, cx}) + ox;
    assign ty = $signed({2'b00, cy}) + oy;
    assign on_screen = !tx[10] && (tx <= X_MAX) && !ty[10] && (ty <= Y_MAX);

    // Off-screen offsets take one cycle each; on-screen ones wait for the ack
    assign step = (state == ST_SWEEP) && (!on_screen || wr_ack_i);

    assign wr_req_o  = (state == ST_SWEEP) && on_screen;
    assign wr_x_o    = wr_req_o ? tx[9:0] : '0;
    assign wr_y_o    = wr_req_o ? ty[8:0] : '0;
    assign wr_data_o = wr_req_o ? mat : '0;
    assign busy_o    = (state == ST_SWEEP);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cursor_x_o <= 10'(H_RES / 2);
            cursor_y_o <= 9'(V_RES / 2);
            state      <= ST_IDLE;
            cx         <= '0;
            cy         <= '0;
            ox         <= '0;
            oy         <= '0;
            mat        <= '0;
        end else begin
            if (accept) begin
                cursor_x_o <= nx_clamp;
                cursor_y_o <= ny_clamp;
            end

            if (paint_start) begin
                cx    <= nx_clamp;
                cy    <= ny_clamp;
                mat   <= btn_i[0] ? 2'b01 : 2'b00;
                ox    <= R_NEG;
                oy    <= R_NEG;
                state <= ST_SWEEP;
            end else if (step) begin
                if (ox == R_POS) begin
                    ox <= R_NEG;
                    if (oy == R_POS)
                        state <= ST_IDLE;
                    else
                        oy <= oy + 11'sd1;
                end else begin
                    ox <= ox + 11'sd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mouse_cursor_painter.sv
// Bench for mouse_cursor_painter: fixed packet vectors, hand-built corner sequences and
// random packets checked against a plain-arithmetic cursor/brush model.
module tb_mouse_cursor_painter;

    localparam int H_RES   = 640;
    localparam int V_RES   = 480;
    localparam int BRUSH_R = 1;

    logic       clk_i = 1'b0;
    logic       reset_i = 1'b1;
    logic [8:0] x_velocity_i = '0;
    logic [8:0] y_velocity_i = '0;
    logic [7:0] btn_i = '0;
    logic       packet_valid_i = 1'b0;
    logic [9:0] cursor_x_o;
    logic [8:0] cursor_y_o;
    logic       wr_req_o;
    logic [9:0] wr_x_o;
    logic [8:0] wr_y_o;
    logic [1:0] wr_data_o;
    logic       wr_ack_i = 1'b0;
    logic       busy_o;

    mouse_cursor_painter #(.H_RES(H_RES), .V_RES(V_RES), .BRUSH_R(BRUSH_R)) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .x_velocity_i(x_velocity_i), .y_velocity_i(y_velocity_i),
        .btn_i(btn_i), .packet_valid_i(packet_valid_i),
        .cursor_x_o(cursor_x_o), .cursor_y_o(cursor_y_o),
        .wr_req_o(wr_req_o), .wr_x_o(wr_x_o), .wr_y_o(wr_y_o),
        .wr_data_o(wr_data_o), .wr_ack_i(wr_ack_i), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int x;
        int y;
        int d;
    } pix_t;

    typedef struct {
        bit         valid;
        logic [7:0] btn;
        logic [8:0] dx;
        logic [8:0] dy;
        int         ex;
        int         ey;
    } vec_t;

    int   total = 0;
    int   bad = 0;
    int   mx, my;
    bit   m_busy;
    pix_t exp_q[$];
    pix_t got_q[$];
    int   ack_mode = 0;
    int   stall_cnt = 0;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // 0: never ack, 1: always ack, 2: random ack, 3: ack after three stall cycles
    always @(negedge clk_i) begin
        case (ack_mode)
            0: wr_ack_i = 1'b0;
            1: wr_ack_i = 1'b1;
            2: wr_ack_i = 1'($urandom % 2);
            default: begin
                if (!wr_req_o) begin
                    wr_ack_i = 1'b0;
                    stall_cnt = 0;
                end else if (stall_cnt == 3) begin
                    wr_ack_i = 1'b1;
                    stall_cnt = 0;
                end else begin
                    wr_ack_i = 1'b0;
                    stall_cnt++;
                end
            end
        endcase
    end

    bit         prev_stall = 1'b0;
    logic [9:0] prev_x;
    logic [8:0] prev_y;
    logic [1:0] prev_d;

    always @(posedge clk_i) begin
        if (reset_i) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_req", int'(wr_req_o), 1);
                chk("stall_x", int'(wr_x_o), int'(prev_x));
                chk("stall_y", int'(wr_y_o), int'(prev_y));
                chk("stall_data", int'(wr_data_o), int'(prev_d));
            end
            if (wr_req_o && wr_ack_i)
                got_q.push_back('{x: int'(wr_x_o), y: int'(wr_y_o), d: int'(wr_data_o)});
            prev_stall = wr_req_o && !wr_ack_i;
            prev_x = wr_x_o;
            prev_y = wr_y_o;
            prev_d = wr_data_o;
        end
    end

    function automatic int clampi(input int v, input int hi);
        if (v < 0) return 0;
        if (v > hi) return hi;
        return v;
    endfunction

    // Model of one packet: cursor integration and, when idle, the brush pixel list
    task automatic model_packet(input bit valid, input logic [7:0] btn,
                                input logic [8:0] dx, input logic [8:0] dy);
        int dxv, dyv;
        if (!(valid && btn[3])) return;
        dxv = btn[6] ? 0 : int'($signed(dx));
        dyv = btn[7] ? 0 : int'($signed(dy));
        mx = clampi(mx + dxv, H_RES - 1);
        my = clampi(my - dyv, V_RES - 1);
        if ((btn[0] || btn[1]) && !m_busy) begin
            m_busy = 1'b1;
            for (int oy = -BRUSH_R; oy <= BRUSH_R; oy++)
                for (int ox = -BRUSH_R; ox <= BRUSH_R; ox++)
                    if (mx + ox >= 0 && mx + ox < H_RES && my + oy >= 0 && my + oy < V_RES)
                        exp_q.push_back('{x: mx + ox, y: my + oy, d: btn[0] ? 1 : 0});
        end
    endtask

    task automatic send_packet(input bit valid, input logic [7:0] btn,
                               input logic [8:0] dx, input logic [8:0] dy);
        @(negedge clk_i);
        btn_i = btn;
        x_velocity_i = dx;
        y_velocity_i = dy;
        packet_valid_i = valid;
        @(negedge clk_i);
        packet_valid_i = 1'b0;
        btn_i = '0;
        model_packet(valid, btn, dx, dy);
        chk("cursor_x", int'(cursor_x_o), mx);
        chk("cursor_y", int'(cursor_y_o), my);
        chk("busy", int'(busy_o), int'(m_busy));
    endtask

    task automatic goto(input int tx, input int ty);
        int step;
        for (int i = 0; i < 10 && (mx != tx || my != ty); i++) begin
            step = tx - mx;
            if (step > 200) step = 200;
            if (step < -200) step = -200;
            send_packet(1'b1, 8'h08, 9'(step), 9'(0));
            step = my - ty;
            if (step > 200) step = 200;
            if (step < -200) step = -200;
            send_packet(1'b1, 8'h08, 9'(0), 9'(step));
        end
    endtask

    task automatic wait_idle_and_compare(input string name);
        int n;
        for (int i = 0; i < 400 && busy_o; i++)
            @(negedge clk_i);
        chk({name, "_idle"}, int'(busy_o), 0);
        chk({name, "_req_low"}, int'(wr_req_o), 0);
        m_busy = 1'b0;
        chk({name, "_count"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk({name, "_wx"}, got_q[i].x, exp_q[i].x);
            chk({name, "_wy"}, got_q[i].y, exp_q[i].y);
            chk({name, "_wd"}, got_q[i].d, exp_q[i].d);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        reset_i = 1'b1;
        @(negedge clk_i);
        reset_i = 1'b0;
        mx = H_RES / 2;
        my = V_RES / 2;
        m_busy = 1'b0;
        got_q.delete();
        exp_q.delete();
    endtask

    vec_t vt[12];

    initial begin
        vt[0]  = '{1'b1, 8'h08, 9'd5,    9'd3,    325, 237};
        vt[1]  = '{1'b1, 8'h08, 9'h1F6,  9'h1FB,  315, 242};
        vt[2]  = '{1'b1, 8'h48, 9'd50,   9'd2,    315, 240};
        vt[3]  = '{1'b1, 8'h01, 9'd20,   9'd20,   315, 240};
        vt[4]  = '{1'b1, 8'h88, 9'd4,    9'd100,  319, 240};
        vt[5]  = '{1'b1, 8'h08, 9'h100,  9'h100,  63,  479};
        vt[6]  = '{1'b1, 8'h08, 9'h100,  9'd0,    0,   479};
        vt[7]  = '{1'b1, 8'h08, 9'd0,    9'd255,  0,   224};
        vt[8]  = '{1'b1, 8'h08, 9'd255,  9'd0,    255, 224};
        vt[9]  = '{1'b1, 8'h08, 9'd255,  9'd0,    510, 224};
        vt[10] = '{1'b1, 8'h08, 9'd255,  9'd0,    639, 224};
        vt[11] = '{1'b0, 8'h08, 9'd5,    9'd5,    639, 224};

        #12;
        chk("rst_cursor_x", int'(cursor_x_o), 320);
        chk("rst_cursor_y", int'(cursor_y_o), 240);
        chk("rst_req", int'(wr_req_o), 0);
        chk("rst_busy", int'(busy_o), 0);
        chk("rst_wx", int'(wr_x_o), 0);
        chk("rst_wy", int'(wr_y_o), 0);
        chk("rst_wd", int'(wr_data_o), 0);
        do_reset();

        // Fixed vectors with hand-computed cursor positions
        ack_mode = 1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk_i);
            btn_i = vt[i].btn;
            x_velocity_i = vt[i].dx;
            y_velocity_i = vt[i].dy;
            packet_valid_i = vt[i].valid;
            @(negedge clk_i);
            packet_valid_i = 1'b0;
            btn_i = '0;
            chk("vec_x", int'(cursor_x_o), vt[i].ex);
            chk("vec_y", int'(cursor_y_o), vt[i].ey);
            chk("vec_busy", int'(busy_o), 0);
            chk("vec_req", int'(wr_req_o), 0);
        end
        do_reset();

        // Near-corner clamping then X saturation through repeated packets
        goto(2, 1);
        send_packet(1'b1, 8'h08, 9'h1F6, 9'h1FB);
        chk("corner_x0", int'(cursor_x_o), 0);
        chk("corner_y6", int'(cursor_y_o), 6);
        for (int i = 0; i < 7; i++)
            send_packet(1'b1, 8'h08, 9'd100, 9'd0);
        chk("sat_x639", int'(cursor_x_o), 639);

        // Sand brush with ack always high
        goto(100, 100);
        send_packet(1'b1, 8'h09, 9'd0, 9'd0);
        wait_idle_and_compare("brush_ack");

        // Erase at corner with stalled acks: only four on-screen pixels
        ack_mode = 3;
        goto(0, 0);
        send_packet(1'b1, 8'h0A, 9'd0, 9'd0);
        chk("corner_pixels", exp_q.size(), 4);
        wait_idle_and_compare("brush_stall");

        // Button packet during a sweep moves the cursor but paints nothing extra
        ack_mode = 0;
        goto(200, 200);
        send_packet(1'b1, 8'h09, 9'd0, 9'd0);
        send_packet(1'b1, 8'h0A, 9'd10, 9'd0);
        chk("drop_cursor_x", int'(cursor_x_o), 210);
        repeat (3) @(negedge clk_i);
        chk("drop_hold_req", int'(wr_req_o), 1);
        ack_mode = 1;
        wait_idle_and_compare("brush_drop");

        // Reset in the middle of a sweep
        ack_mode = 0;
        send_packet(1'b1, 8'h09, 9'd0, 9'd0);
        repeat (2) @(negedge clk_i);
        #2 reset_i = 1'b1;
        #1;
        chk("mid_rst_req", int'(wr_req_o), 0);
        chk("mid_rst_busy", int'(busy_o), 0);
        chk("mid_rst_x", int'(cursor_x_o), 320);
        chk("mid_rst_y", int'(cursor_y_o), 240);
        @(negedge clk_i);
        reset_i = 1'b0;
        mx = H_RES / 2;
        my = V_RES / 2;
        m_busy = 1'b0;
        got_q.delete();
        exp_q.delete();

        // Random packets with random ack behaviour
        ack_mode = 2;
        for (int i = 0; i < 150; i++) begin
            logic [7:0] b;
            b = 8'($urandom) & 8'hC3;
            b[3] = ($urandom % 8) != 0;
            send_packet(($urandom % 8) != 0, b, 9'($urandom), 9'($urandom));
            if (m_busy)
                wait_idle_and_compare("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
